// File: rtl/set_scan_scheduler_if.sv
// Job and cell-bus signals of the set-scan scheduler.
// master: scheduler side; slave: job requester plus the three cells.
interface set_scan_scheduler_if;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;
    logic [5:0]  now;
    logic [3:0]  center_x0;
    logic [3:0]  center_y0;
    logic [3:0]  center_r0;
    logic [3:0]  center_x1;
    logic [3:0]  center_y1;
    logic [3:0]  center_r1;
    logic [3:0]  center_x2;
    logic [3:0]  center_y2;
    logic [3:0]  center_r2;
    logic        hit_a;
    logic        hit_b;
    logic        hit_c;

    modport master (
        input  en, central, radius, mode,
        input  hit_a, hit_b, hit_c,
        output busy, valid, candidate, now,
        output center_x0, center_y0, center_r0,
        output center_x1, center_y1, center_r1,
        output center_x2, center_y2, center_r2
    );

    modport slave (
        output en, central, radius, mode,
        output hit_a, hit_b, hit_c,
        input  busy, valid, candidate, now,
        input  center_x0, center_y0, center_r0,
        input  center_x1, center_y1, center_r1,
        input  center_x2, center_y2, center_r2
    );
endinterface

// File: rtl/set_scan_scheduler.sv
// Walks the 8x8 grid, feeds three circle cells and counts
// points whose hit bits satisfy the captured set function.
module set_scan_scheduler #(
    parameter int RES_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    set_scan_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [23:0]        central_q;
    logic [11:0]        radius_q;
    logic [1:0]         mode_q;
    logic [6:0]         count_q, count_d;
    logic [RES_LAT-1:0] tag_q;
    logic [1:0]         drain_q;
    logic [5:0]         now_q;
    logic               busy_q;
    logic               valid_q;
    logic [7:0]         cand_q;
    logic               start;
    logic               f;

    assign start = (state_q == IDLE) && bus.en;

    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.candidate = cand_q;
    assign bus.now       = now_q;
    assign bus.center_x0 = central_q[23:20];
    assign bus.center_y0 = central_q[19:16];
    assign bus.center_x1 = central_q[15:12];
    assign bus.center_y1 = central_q[11:8];
    assign bus.center_x2 = central_q[7:4];
    assign bus.center_y2 = central_q[3:0];
    assign bus.center_r0 = radius_q[11:8];
    assign bus.center_r1 = radius_q[7:4];
    assign bus.center_r2 = radius_q[3:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state; drain ends once the last tag has emerged
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.en) state_d = SCAN;
            SCAN:    if (now_q == 6'd63) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'(RES_LAT - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Set function of the emerging hit bits, and the counter update
    always_comb begin
        f = 1'b0;
        unique case (1'b1)
            (mode_q == 2'b00): f = bus.hit_a;
            (mode_q == 2'b01): f = bus.hit_a & bus.hit_b;
            (mode_q == 2'b10): f = bus.hit_a ^ bus.hit_b;
            (mode_q == 2'b11): f = bus.hit_a & bus.hit_b & bus.hit_c;
        endcase
        count_d = count_q + 7'(tag_q[RES_LAT-1] & f);
        if (start) count_d = 7'd0;
    end

    // Captured job parameters, only written at the accept edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
        end else if (start) begin
            central_q <= bus.central;
            radius_q  <= bus.radius;
            mode_q    <= bus.mode;
        end
    end

    // Issue tags, drain timer, counter and point index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q   <= '0;
            drain_q <= '0;
            count_q <= '0;
            now_q   <= '0;
        end else begin
            tag_q[0] <= (state_q == SCAN);
            for (int i = 1; i < RES_LAT; i++) tag_q[i] <= tag_q[i-1];
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
            count_q <= count_d;
            if (state_q == SCAN && now_q != 6'd63)
                now_q <= now_q + 6'd1;
            else if (state_q == IDLE || state_d == IDLE)
                now_q <= 6'd0;
        end
    end

    // Registered status outputs; candidate is zero outside the pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cand_q  <= 8'd0;
        end else begin
            busy_q  <= (state_d != IDLE);
            valid_q <= (state_d == DONE);
            cand_q  <= (state_d == DONE) ? {1'b0, count_d} : 8'd0;
        end
    end
endmodule

// File: tb/tb_set_scan_scheduler.sv
// Bench for set_scan_scheduler: ideal delayed cell models,
// directed jobs plus random jobs against a grid-count model.
module tb_set_scan_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    set_scan_scheduler_if i1 ();
    set_scan_scheduler_if i3 ();

    set_scan_scheduler #(.RES_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
    set_scan_scheduler #(.RES_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(i3));

    function automatic bit in_c(int x, int y, int xc, int yc, int r);
        return ((x - xc) * (x - xc) + (y - yc) * (y - yc)) <= r * r;
    endfunction

    function automatic logic [2:0] cell3(logic [5:0] n,
        logic [3:0] x0, logic [3:0] y0, logic [3:0] r0,
        logic [3:0] x1, logic [3:0] y1, logic [3:0] r1,
        logic [3:0] x2, logic [3:0] y2, logic [3:0] r2);
        int x = int'(n[5:3]) + 1;
        int y = int'(n[2:0]) + 1;
        return {in_c(x, y, int'(x0), int'(y0), int'(r0)),
                in_c(x, y, int'(x1), int'(y1), int'(r1)),
                in_c(x, y, int'(x2), int'(y2), int'(r2))};
    endfunction

    logic [2:0] h1, h3a, h3b, h3c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h1 <= '0; h3a <= '0; h3b <= '0; h3c <= '0;
        end else begin
            h1  <= cell3(i1.now, i1.center_x0, i1.center_y0, i1.center_r0,
                         i1.center_x1, i1.center_y1, i1.center_r1,
                         i1.center_x2, i1.center_y2, i1.center_r2);
            h3a <= cell3(i3.now, i3.center_x0, i3.center_y0, i3.center_r0,
                         i3.center_x1, i3.center_y1, i3.center_r1,
                         i3.center_x2, i3.center_y2, i3.center_r2);
            h3b <= h3a;
            h3c <= h3b;
        end
    end

    assign i1.hit_a = h1[2];
    assign i1.hit_b = h1[1];
    assign i1.hit_c = h1[0];
    assign i3.hit_a = h3c[2];
    assign i3.hit_b = h3c[1];
    assign i3.hit_c = h3c[0];

    function automatic int ref_count(logic [23:0] c, logic [11:0] r, logic [1:0] m);
        int n = 0;
        for (int x = 1; x <= 8; x++)
            for (int y = 1; y <= 8; y++) begin
                bit a = in_c(x, y, int'(c[23:20]), int'(c[19:16]), int'(r[11:8]));
                bit b = in_c(x, y, int'(c[15:12]), int'(c[11:8]), int'(r[7:4]));
                bit d = in_c(x, y, int'(c[7:4]), int'(c[3:0]), int'(r[3:0]));
                bit s;
                case (m)
                    2'b00:   s = a;
                    2'b01:   s = a && b;
                    2'b10:   s = a != b;
                    default: s = a && b && d;
                endcase
                if (s) n++;
            end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(int sel, logic e, logic [23:0] c, logic [11:0] r, logic [1:0] m);
        if (sel != 0) begin
            i3.en = e; i3.central = c; i3.radius = r; i3.mode = m;
        end else begin
            i1.en = e; i1.central = c; i1.radius = r; i1.mode = m;
        end
    endtask

    function automatic logic [35:0] ctrs(int sel);
        if (sel != 0)
            return {i3.center_x0, i3.center_y0, i3.center_x1, i3.center_y1,
                    i3.center_x2, i3.center_y2,
                    i3.center_r0, i3.center_r1, i3.center_r2};
        return {i1.center_x0, i1.center_y0, i1.center_x1, i1.center_y1,
                i1.center_x2, i1.center_y2,
                i1.center_r0, i1.center_r1, i1.center_r2};
    endfunction

    task automatic run_job(int sel, logic [23:0] c, logic [11:0] r,
                           logic [1:0] m, bit glitch,
                           output int vcyc, output int vabs,
                           output logic [7:0] cand);
        int lat = (sel != 0) ? 3 : 1;
        int nval = 0;
        logic ob, ov;
        logic [7:0] oc;
        logic [5:0] on;
        vcyc = -1; vabs = -1; cand = 8'hxx;
        drv(sel, 1'b1, c, r, m);
        @(posedge clk);
        #1 drv(sel, 1'b0, 24'($urandom), 12'($urandom), ~m);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            ob = (sel != 0) ? i3.busy : i1.busy;
            ov = (sel != 0) ? i3.valid : i1.valid;
            oc = (sel != 0) ? i3.candidate : i1.candidate;
            on = (sel != 0) ? i3.now : i1.now;
            drv(sel, glitch && (k == 10 || k == 40),
                24'($urandom), 12'($urandom), 2'($urandom));
            if (k <= 65 + lat) chk("busy_high", 32'(ob), 1);
            if (k <= 64) chk("now_scan", 32'(on), k - 1);
            else if (k <= 64 + lat) chk("now_drain", 32'(on), 63);
            if (ov) begin
                nval++;
                if (vcyc < 0) begin vcyc = k; vabs = cyc_cnt; cand = oc; end
            end else begin
                chk("cand_zero", 32'(oc), 0);
            end
            if (vcyc > 0 && k == vcyc + 1) begin
                chk("busy_fall", 32'(ob), 0);
                break;
            end
        end
        drv(sel, 1'b0, 24'h0, 12'h0, 2'b00);
        chk("valid_count", nval, 1);
        chk("valid_cycle", vcyc, 65 + lat);
        chk("centers_held", ctrs(sel), {c, r});
    endtask

    initial begin
        int vc, va, va2, n1;
        logic [7:0] cd;
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0] m;
        drv(0, 1'b0, 24'h0, 12'h0, 2'b00);
        drv(1, 1'b0, 24'h0, 12'h0, 2'b00);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(i1.busy), 0);
        chk("rst_valid", 32'(i1.valid), 0);
        chk("rst_cand", 32'(i1.candidate), 0);
        chk("rst_now", 32'(i1.now), 0);
        chk("rst_ctrs", ctrs(0), 0);
        chk("rst_busy3", 32'(i3.busy), 0);
        rst = 1'b1;
        @(negedge clk);

        run_job(0, 24'h44_44_44, 12'h222, 2'b00, 0, vc, va, cd);
        chk("a_r2", cd, 13);
        run_job(0, 24'h44_44_44, 12'h222, 2'b01, 0, vc, va, cd);
        chk("and_ab", cd, 13);
        run_job(0, 24'h44_44_44, 12'h222, 2'b10, 0, vc, va, cd);
        chk("xor_ab", cd, 0);
        run_job(0, 24'h44_44_44, 12'h222, 2'b11, 0, vc, va, cd);
        chk("and_abc", cd, 13);
        run_job(0, 24'h44_11_11, 12'hF00, 2'b00, 0, vc, va, cd);
        chk("full_grid", cd, 8'h40);
        run_job(0, 24'h11_44_44, 12'h022, 2'b00, 0, vc, va, cd);
        chk("corner_r0", cd, 1);

        run_job(0, 24'h44_35_62, 12'h234, 2'b10, 1, vc, va, cd);
        chk("glitch_ignored", cd, ref_count(24'h44_35_62, 12'h234, 2'b10));
        run_job(0, 24'h44_44_44, 12'h222, 2'b00, 0, vc, va2, cd);
        chk("b2b_result", cd, 13);
        chk("b2b_spacing", va2 - va, 67);

        drv(0, 1'b1, 24'h44_44_44, 12'h222, 2'b00);
        @(posedge clk);
        #1 drv(0, 1'b0, 24'h0, 12'h0, 2'b00);
        repeat (29) @(posedge clk);
        #2 chk("pre_rst_now", 32'(i1.now), 29);
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(i1.busy), 0);
        chk("arst_valid", 32'(i1.valid), 0);
        chk("arst_cand", 32'(i1.candidate), 0);
        chk("arst_now", 32'(i1.now), 0);
        chk("arst_ctrs", ctrs(0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n1 = 0;
        repeat (80) begin
            @(negedge clk);
            if (i1.valid) n1++;
        end
        chk("no_valid_after_rst", n1, 0);
        run_job(0, 24'h44_44_44, 12'h222, 2'b00, 0, vc, va, cd);
        chk("post_rst_job", cd, 13);

        run_job(1, 24'h44_44_44, 12'h222, 2'b00, 0, vc, va, cd);
        chk("lat3_a_r2", cd, 13);

        for (int t = 0; t < 8; t++) begin
            c = {4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)),
                 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8)),
                 4'($urandom_range(1, 8)), 4'($urandom_range(1, 8))};
            r = 12'($urandom);
            m = 2'($urandom);
            run_job(t % 3 == 2 ? 1 : 0, c, r, m, t[0], vc, va, cd);
            chk("rand_job", cd, ref_count(c, r, m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/set_scan_scheduler.md
# set_scan_scheduler

Sequencing controller for the three-circle set-membership datapath. On `en` it captures circle centres, radii and mode. It then walks all 64 points of the 8x8 grid, one per cycle, driving the shared point index and circle parameters to the three point-in-circle cells (A, B, C). It combines their registered hit results per mode, counts matching points, and reports the count with a one-cycle `valid` pulse.

## Interface
- `RES_LAT`, default 1: cycles from a point index being driven on `now` to its registered hit bits appearing on `hit_a/b/c`; legal range 1..3.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; sampled only while `busy`=0.
- `central`  in  24  centres {xA,yA,xB,yB,xC,yC}, 4 bits each, MSB first, legal 1..8.
- `radius`  in  12  radii {rA,rB,rC}, 4 bits each, MSB first.
- `mode`  in  2  set function: 00 A; 01 A∩B; 10 A⊕B; 11 A∩B∩C.
- `busy`  out  1  job in progress; new `en` ignored.
- `valid`  out  1  one-cycle pulse; `candidate` is valid.
- `candidate`  out  8  number of grid points satisfying `mode` (0..64).
- `now`  out  6  current point index; x = now[5:3]+1, y = now[2:0]+1.
- `center_x0/1/2`, `center_y0/1/2`, `center_r0/1/2`  out  4 each  captured parameters of A/B/C; registered and stable for the whole job.
- `hit_a`, `hit_b`, `hit_c`  in  1 each  registered cell results for the point issued RES_LAT cycles earlier; 1 when (x-xc)²+(y-yc)² ≤ r².

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE
  - `busy`=0; `now`=0.
  - On `en`=1: capture `central`, `radius` and `mode` into registers, clear the counter, go to SCAN.
- SCAN
  - `now` starts at 0 and increments by 1 per cycle, x-major (y inner loop).
  - After the cycle with `now`=63, go to DRAIN.
  - A RES_LAT-deep shift register of issue tags marks which later cycles carry a real result.
- DRAIN
  - Lasts until the last tag has emerged: RES_LAT cycles.
  - `now` holds 63.
- Accumulation
  - In any cycle whose emerging tag is 1, evaluate f(hit_a, hit_b, hit_c) using the captured mode.
  - Add 1 to the 7-bit counter when f=1.
  - The counter cannot overflow; maximum is 64.
- DONE
  - Exactly one cycle.
  - `valid`=1 and `candidate`={1'b0, count}.
  - Next state is IDLE.
- `candidate` is 0 in every cycle where `valid`=0.
- `hit_*` inputs are ignored whenever the emerging tag is 0.
- `en` while `busy`=1 is ignored and has no effect on the captured parameters.
- `mode` changes during a job have no effect, because the captured copy is used.
- Reset (`rst`=0, any state, including mid-scan):
  - FSM goes to IDLE.
  - `busy`=0, `valid`=0, `candidate`=0, `now`=0.
  - `center_*`=0; counter and tags cleared.
  - The job in progress is discarded; no `valid` is issued for it.

## Timing
- Reference cycle: `en` sampled high at edge E0.
- SCAN
  - Cycles 1..64 after E0; `now`=k in cycle k+1.
  - `busy`=1 from the cycle after E0.
- DRAIN: cycles 65..64+RES_LAT.
- DONE: cycle 65+RES_LAT, which is 66 at the default.
  - `valid`=1 in this cycle only.
  - `busy` stays 1 during DONE.
- Return to IDLE: cycle 66+RES_LAT.
  - `busy`=0.
  - An `en` in this cycle is accepted, so back-to-back jobs are 66+RES_LAT cycles apart.
- Outputs `busy`, `valid`, `candidate`, `now` and `center_*` are all registered.
- `center_*` change only at the capture edge.

## Test plan
- A=(4,4,r=2), mode 00, default RES_LAT, ideal cell model -> single `valid` in cycle 66, `candidate`=13, `busy` falls in cycle 67.
- A=B=C=(4,4,r=2) -> mode 01 gives 13; mode 10 gives 0; mode 11 gives 13.
- A=(4,4,r=15), mode 00 -> `candidate`=64 (0x40), confirming no counter wrap. Separately, A=(1,1,r=0) -> `candidate`=1.
- Pulse `en` at cycles 10 and 40 of a job, with different `central` values -> both ignored; result matches the first job. Then raise `en` in the cycle `busy` falls -> second job starts immediately, its `valid` arrives 67 cycles after the first.
- Assert `rst` low at SCAN cycle 30 -> all outputs 0 asynchronously, no `valid` issued. A new job after reset release completes correctly.
- RES_LAT=3 with a matching delayed cell model, A=(4,4,r=2) -> `valid` at cycle 68, `candidate`=13; `now` sequence 0..63 observed exactly once.
